// File: rtl/note_display_ctrl_if.sv
// rtl/note_display_ctrl_if.sv - note request, map_rom and LCD port bundle for note_display_ctrl
//
// Parameter: CHAR_SLOTS - number of LCD character cells (sets the cursor width)
// Signals:
//   note_valid/note_idx/note_ready - note request handshake (requester -> controller)
//   rom_idx -> rom_left/rom_right  - combinational map_rom lookup
//   lcd_data/lcd_valid/lcd_ready   - LCD write port (bit8 = RS, bits7:0 = byte)
//   cursor/busy/notes_shown        - controller status
// Modports: slave = controller view, master = requester/ROM/LCD environment view.
interface note_display_ctrl_if #(
  parameter int CHAR_SLOTS = 32
);
  localparam int CW = $clog2(CHAR_SLOTS);

  logic          note_valid;
  logic [5:0]    note_idx;
  logic          note_ready;
  logic [5:0]    rom_idx;
  logic [8:0]    rom_left;
  logic [8:0]    rom_right;
  logic [8:0]    lcd_data;
  logic          lcd_valid;
  logic          lcd_ready;
  logic [CW-1:0] cursor;
  logic          busy;
  logic [15:0]   notes_shown;

  modport slave (
    input  note_valid, note_idx, rom_left, rom_right, lcd_ready,
    output note_ready, rom_idx, lcd_data, lcd_valid, cursor, busy, notes_shown
  );

  modport master (
    output note_valid, note_idx, rom_left, rom_right, lcd_ready,
    input  note_ready, rom_idx, lcd_data, lcd_valid, cursor, busy, notes_shown
  );
endinterface

// File: rtl/note_display_ctrl.sv
// rtl/note_display_ctrl.sv - writes one looked-up note (two characters) per request to a character LCD
//
// Parameter: CHAR_SLOTS - total LCD cells, even; line 2 starts at CHAR_SLOTS/2
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - note_display_ctrl_if.slave (note handshake, map_rom lookup, LCD port, status)
// Optional feature: define NOTE_DISP_DEDUP_EN to skip a note equal to the last fully written one.
module note_display_ctrl #(
  parameter int CHAR_SLOTS = 32
) (
  input  logic                clk,
  input  logic                rst,
  note_display_ctrl_if.slave  bus
);
  localparam int            CW   = $clog2(CHAR_SLOTS);
  localparam logic [CW-1:0] HALF = CW'(CHAR_SLOTS / 2);
  localparam logic [CW-1:0] LAST = CW'(CHAR_SLOTS - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, CMD, LEFT, RIGHT} state_t;

  state_t        state_q;
  logic [5:0]    rom_idx_q;
  logic [8:0]    left_q;
  logic [8:0]    right_q;
  logic [8:0]    lcd_data_q;
  logic          lcd_valid_q;
  logic [CW-1:0] cursor_q;
  logic [15:0]   notes_shown_q;
  logic          busy_q;
  logic          note_ready_q;
`ifdef NOTE_DISP_DEDUP_EN
  logic [5:0]    last_idx_q;
  logic          last_vld_q;
`endif

  // All outputs are registered; each transition sets the values seen in the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rom_idx_q     <= '0;
      left_q        <= '0;
      right_q       <= '0;
      lcd_data_q    <= '0;
      lcd_valid_q   <= 1'b0;
      cursor_q      <= '0;
      notes_shown_q <= '0;
      busy_q        <= 1'b0;
      note_ready_q  <= 1'b0;
`ifdef NOTE_DISP_DEDUP_EN
      last_idx_q    <= '0;
      last_vld_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // note_ready_q is low for the first cycle after reset, so gate acceptance on it.
          if (note_ready_q && bus.note_valid) begin
            rom_idx_q    <= bus.note_idx;
            state_q      <= LOOKUP;
            note_ready_q <= 1'b0;
            busy_q       <= 1'b1;
          end else begin
            note_ready_q <= 1'b1;
          end
        end
        LOOKUP: begin
          left_q  <= bus.rom_left;
          right_q <= bus.rom_right;
`ifdef NOTE_DISP_DEDUP_EN
          if (last_vld_q && (last_idx_q == rom_idx_q)) begin
            state_q      <= IDLE;
            note_ready_q <= 1'b1;
            busy_q       <= 1'b0;
          end else
`endif
          if ((cursor_q == '0) || (cursor_q == HALF)) begin
            state_q     <= CMD;
            lcd_data_q  <= (cursor_q == '0) ? 9'h080 : 9'h0C0;
            lcd_valid_q <= 1'b1;
          end else begin
            // Present the left char straight from the ROM; left_q catches it on the same edge.
            state_q     <= LEFT;
            lcd_data_q  <= bus.rom_left;
            lcd_valid_q <= 1'b1;
          end
        end
        CMD: begin
          if (bus.lcd_ready) begin
            state_q    <= LEFT;
            lcd_data_q <= left_q;
          end
        end
        LEFT: begin
          // Cursor is even here, so +1 can never wrap.
          if (bus.lcd_ready) begin
            state_q    <= RIGHT;
            cursor_q   <= cursor_q + CW'(1);
            lcd_data_q <= right_q;
          end
        end
        RIGHT: begin
          if (bus.lcd_ready) begin
            state_q       <= IDLE;
            cursor_q      <= (cursor_q == LAST) ? '0 : cursor_q + CW'(1);
            notes_shown_q <= (notes_shown_q == 16'hFFFF) ? notes_shown_q : notes_shown_q + 16'd1;
            lcd_data_q    <= '0;
            lcd_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            note_ready_q  <= 1'b1;
`ifdef NOTE_DISP_DEDUP_EN
            last_idx_q    <= rom_idx_q;
            last_vld_q    <= 1'b1;
`endif
          end
        end
        default: begin
          state_q      <= IDLE;
          lcd_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
          note_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.note_ready  = note_ready_q;
  assign bus.rom_idx     = rom_idx_q;
  assign bus.lcd_data    = lcd_data_q;
  assign bus.lcd_valid   = lcd_valid_q;
  assign bus.cursor      = cursor_q;
  assign bus.busy        = busy_q;
  assign bus.notes_shown = notes_shown_q;
endmodule

// File: tb/tb_note_display_ctrl.sv
// tb/tb_note_display_ctrl.sv - directed self-checking bench for note_display_ctrl
module tb_note_display_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  note_display_ctrl_if #(.CHAR_SLOTS(32)) bus ();
  note_display_ctrl #(.CHAR_SLOTS(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad = 0;
  logic [8:0] log_q[$];
  logic [8:0] exp_q[$];

  function automatic logic [8:0] rom_l(input logic [5:0] i);
    return {3'b101, i};
  endfunction
  function automatic logic [8:0] rom_r(input logic [5:0] i);
    return {3'b110, i};
  endfunction

  assign bus.rom_left  = rom_l(bus.rom_idx);
  assign bus.rom_right = rom_r(bus.rom_idx);

  always @(posedge clk) if (!rst && bus.lcd_valid && bus.lcd_ready) log_q.push_back(bus.lcd_data);

  // Called at a negedge; returns at the negedge following the accepting edge (LOOKUP cycle).
  task send_note(input logic [5:0] idx);
    int n;
    n = 0;
    bus.note_idx = idx;
    bus.note_valid = 1'b1;
    while (!bus.note_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin total++; bad++; $display("FAIL send_note_timeout idx=%0d: ready got 0 want 1", idx); end
    @(negedge clk);
    bus.note_valid = 1'b0;
  endtask

  task wait_idle;
    int n;
    n = 0;
    while ((bus.busy || !bus.note_ready) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin total++; bad++; $display("FAIL wait_idle_timeout: busy got %0b want 0", bus.busy); end
  endtask

  task compare_log(input string name);
    total++;
    if (log_q.size() != exp_q.size()) begin
      bad++; $display("FAIL %s_len: got %0d want %0d", name, log_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (log_q[i] !== exp_q[i]) begin bad++; $display("FAIL %s[%0d]: got %h want %h", name, i, log_q[i], exp_q[i]); end
      end
    end
  endtask

  task test_reset;
    rst = 1'b1; bus.note_valid = 1'b0; bus.note_idx = '0; bus.lcd_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    total++; if (bus.lcd_valid !== 1'b0) begin bad++; $display("FAIL rst_lcd_valid: got %b want 0", bus.lcd_valid); end
    total++; if (bus.lcd_data !== 9'h000) begin bad++; $display("FAIL rst_lcd_data: got %h want 000", bus.lcd_data); end
    total++; if (bus.cursor !== 5'd0) begin bad++; $display("FAIL rst_cursor: got %0d want 0", bus.cursor); end
    total++; if (bus.notes_shown !== 16'd0) begin bad++; $display("FAIL rst_notes: got %0d want 0", bus.notes_shown); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    total++; if (bus.note_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus.note_ready); end
    total++; if (bus.rom_idx !== 6'd0) begin bad++; $display("FAIL rst_rom_idx: got %0d want 0", bus.rom_idx); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.note_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %b want 1", bus.note_ready); end
  endtask

  task test_first_note;
    bus.lcd_ready = 1'b1;
    log_q.delete();
    send_note(6'd5);
    total++; if (bus.lcd_valid !== 1'b0) begin bad++; $display("FAIL lookup_valid: got %b want 0", bus.lcd_valid); end
    total++; if (bus.note_ready !== 1'b0) begin bad++; $display("FAIL lookup_ready: got %b want 0", bus.note_ready); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL lookup_busy: got %b want 1", bus.busy); end
    total++; if (bus.rom_idx !== 6'd5) begin bad++; $display("FAIL lookup_rom_idx: got %0d want 5", bus.rom_idx); end
    @(negedge clk);
    total++; if (bus.lcd_valid !== 1'b1) begin bad++; $display("FAIL cmd_valid: got %b want 1", bus.lcd_valid); end
    total++; if (bus.lcd_data !== 9'h080) begin bad++; $display("FAIL cmd_data: got %h want 080", bus.lcd_data); end
    wait_idle();
    exp_q = '{9'h080, 9'h145, 9'h185};
    compare_log("first_log");
    total++; if (bus.cursor !== 5'd2) begin bad++; $display("FAIL first_cursor: got %0d want 2", bus.cursor); end
    total++; if (bus.notes_shown !== 16'd1) begin bad++; $display("FAIL first_notes: got %0d want 1", bus.notes_shown); end
  endtask

  task test_stall;
    bus.lcd_ready = 1'b0;
    send_note(6'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (bus.lcd_valid !== 1'b1 || bus.lcd_data !== 9'h143) begin bad++; $display("FAIL stall_hold[%0d]: got %b/%h want 1/143", i, bus.lcd_valid, bus.lcd_data); end
      total++; if (bus.cursor !== 5'd2) begin bad++; $display("FAIL stall_cursor[%0d]: got %0d want 2", i, bus.cursor); end
    end
    bus.lcd_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.lcd_data !== 9'h183 || bus.cursor !== 5'd3) begin bad++; $display("FAIL stall_right: got %h/%0d want 183/3", bus.lcd_data, bus.cursor); end
    @(negedge clk);
    total++; if (bus.cursor !== 5'd4 || bus.notes_shown !== 16'd2) begin bad++; $display("FAIL stall_done: got %0d/%0d want 4/2", bus.cursor, bus.notes_shown); end
  endtask

  task test_latency;
    bus.lcd_ready = 1'b1;
    send_note(6'd7);
    @(negedge clk);
    total++; if (bus.lcd_valid !== 1'b1 || bus.lcd_data !== 9'h147) begin bad++; $display("FAIL lat_left: got %b/%h want 1/147", bus.lcd_valid, bus.lcd_data); end
    @(negedge clk);
    total++; if (bus.busy !== 1'b1 || bus.lcd_data !== 9'h187) begin bad++; $display("FAIL lat_right: got %b/%h want 1/187", bus.busy, bus.lcd_data); end
    @(negedge clk);
    total++; if (bus.busy !== 1'b0 || bus.note_ready !== 1'b1 || bus.lcd_valid !== 1'b0) begin bad++; $display("FAIL lat_idle: got busy=%b ready=%b valid=%b want 0 1 0", bus.busy, bus.note_ready, bus.lcd_valid); end
    total++; if (bus.cursor !== 5'd6 || bus.notes_shown !== 16'd3) begin bad++; $display("FAIL lat_status: got %0d/%0d want 6/3", bus.cursor, bus.notes_shown); end
  endtask

  task test_line_wrap;
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    bus.lcd_ready = 1'b1;
    log_q.delete(); exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      if (k == 0) exp_q.push_back(9'h080);
      if (k == 8) exp_q.push_back(9'h0C0);
      exp_q.push_back(rom_l(6'(k)));
      exp_q.push_back(rom_r(6'(k)));
      send_note(6'(k));
    end
    wait_idle();
    compare_log("wrap_log");
    total++; if (bus.cursor !== 5'd0 || bus.notes_shown !== 16'd16) begin bad++; $display("FAIL wrap_status: got %0d/%0d want 0/16", bus.cursor, bus.notes_shown); end
    log_q.delete();
    send_note(6'd20);
    wait_idle();
    exp_q = '{9'h080, 9'h154, 9'h194};
    compare_log("wrap17_log");
    total++; if (bus.cursor !== 5'd2 || bus.notes_shown !== 16'd17) begin bad++; $display("FAIL wrap17_status: got %0d/%0d want 2/17", bus.cursor, bus.notes_shown); end
  endtask

  task test_hold_valid;
    int acc;
    int overlap;
    logic took;
    acc = 0; overlap = 0;
    bus.lcd_ready = 1'b1;
    bus.note_idx = 6'd30;
    bus.note_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.note_ready && (bus.busy || bus.lcd_valid)) overlap++;
      took = bus.note_ready;
      if (took) acc++;
      @(negedge clk);
      if (took) bus.note_idx = bus.note_idx + 6'd1;
    end
    bus.note_valid = 1'b0;
    wait_idle();
    total++; if (overlap != 0) begin bad++; $display("FAIL hold_overlap: got %0d want 0", overlap); end
    total++; if (acc < 8) begin bad++; $display("FAIL hold_accepts: got %0d want >=8", acc); end
    total++; if (bus.notes_shown !== 16'(17 + acc)) begin bad++; $display("FAIL hold_notes: got %0d want %0d", bus.notes_shown, 17 + acc); end
    total++; if (bus.cursor[0] !== 1'b0) begin bad++; $display("FAIL hold_cursor_even: got %0d want even", bus.cursor); end
  endtask

  task test_reset_mid;
    int n;
    bus.lcd_ready = 1'b1;
    send_note(6'd40);
    n = 0;
    while (!(bus.lcd_valid && bus.lcd_data == 9'h1A8) && n < 50) begin @(negedge clk); n++; end
    bus.lcd_ready = 1'b0;
    if (n >= 50) begin total++; bad++; $display("FAIL rmid_timeout: got no RIGHT want RIGHT"); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.lcd_valid !== 1'b0 || bus.lcd_data !== 9'h000) begin bad++; $display("FAIL rmid_lcd: got %b/%h want 0/000", bus.lcd_valid, bus.lcd_data); end
    total++; if (bus.cursor !== 5'd0 || bus.notes_shown !== 16'd0 || bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_status: got %0d/%0d/%b want 0/0/0", bus.cursor, bus.notes_shown, bus.busy); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.note_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready: got %b want 1", bus.note_ready); end
  endtask

  task test_dedup;
    bus.lcd_ready = 1'b1;
    log_q.delete();
    send_note(6'd9); wait_idle();
    send_note(6'd9); wait_idle();
    send_note(6'd10); wait_idle();
`ifdef NOTE_DISP_DEDUP_EN
    exp_q = '{9'h080, 9'h149, 9'h189, 9'h14A, 9'h18A};
    compare_log("dedup_log");
    total++; if (bus.notes_shown !== 16'd2 || bus.cursor !== 5'd4) begin bad++; $display("FAIL dedup_status: got %0d/%0d want 2/4", bus.notes_shown, bus.cursor); end
`else
    exp_q = '{9'h080, 9'h149, 9'h189, 9'h149, 9'h189, 9'h14A, 9'h18A};
    compare_log("dedup_log");
    total++; if (bus.notes_shown !== 16'd3 || bus.cursor !== 5'd6) begin bad++; $display("FAIL dedup_status: got %0d/%0d want 3/6", bus.notes_shown, bus.cursor); end
`endif
  endtask

  initial begin
    test_reset();
    test_first_note();
    test_stall();
    test_latency();
    test_line_wrap();
    test_hold_valid();
    test_reset_mid();
    test_dedup();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
